// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Round-robin arbiter that shares one burst read/write req/ack interface of
//   sdram_top between two clients. The granted client's burst command is
//   latched, driven to sdram_top, and the per-word acks / read data are steered
//   back to that client. A burst that sees no matching ack for TIMEOUT cycles
//   is aborted and reported with an error pulse.
//
// Ports
//   sys_clk, reset_n        clock (posedge) / asynchronous active-low reset
//   sdram_init_done         sdram_top ready; no grant while low
//   cN_req/we/addr/len      client N burst command (level request)
//   cN_wdata                client N write word, advanced on each cN_ack
//   cN_ack/rdata            per-word strobe and read data to client N
//   cN_done/cN_err          1-cycle completion / timeout-abort pulses
//   sdram_wr_req/rd_req     burst requests to sdram_top
//   sdram_wr_ack/rd_ack     per-word acks from sdram_top
//   sys_wraddr/sys_rdaddr   latched burst start addresses
//   sdwr_byte/sdrd_byte     latched burst lengths
//   sys_data_in             granted client's write data (0 when idle)
//   sys_data_out            read data from sdram_top
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int LW      = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          sdram_init_done,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [LW-1:0] c0_len,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_ack,
    output logic [DW-1:0] c0_rdata,
    output logic          c0_done,
    output logic          c0_err,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [LW-1:0] c1_len,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_ack,
    output logic [DW-1:0] c1_rdata,
    output logic          c1_done,
    output logic          c1_err,
    output logic          sdram_wr_req,
    output logic          sdram_rd_req,
    input  logic          sdram_wr_ack,
    input  logic          sdram_rd_ack,
    output logic [AW-1:0] sys_wraddr,
    output logic [AW-1:0] sys_rdaddr,
    output logic [LW-1:0] sdwr_byte,
    output logic [LW-1:0] sdrd_byte,
    output logic [DW-1:0] sys_data_in,
    input  logic [DW-1:0] sys_data_out
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;      // doubles as last_grant
    logic          we_q, we_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          wr_req_q, wr_req_d;
    logic          rd_req_q, rd_req_d;
    logic [AW-1:0] wraddr_q, wraddr_d;
    logic [AW-1:0] rdaddr_q, rdaddr_d;
    logic [LW-1:0] wrlen_q, wrlen_d;
    logic [LW-1:0] rdlen_q, rdlen_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;

    logic          active;
    logic          ack_match;
    logic [LW-1:0] cur_len;
    logic [LW-1:0] cnt_inc;

    assign active    = (state_q == REQ) || (state_q == BURST);
    assign ack_match = we_q ? sdram_wr_ack : sdram_rd_ack;
    assign cur_len   = we_q ? wrlen_q : rdlen_q;
    assign cnt_inc   = cnt_q + LW'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b1;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            timer_q  <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            wraddr_q <= '0;
            rdaddr_q <= '0;
            wrlen_q  <= '0;
            rdlen_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            wraddr_q <= wraddr_d;
            rdaddr_q <= rdaddr_d;
            wrlen_q  <= wrlen_d;
            rdlen_q  <= rdlen_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        logic          pick;
        logic          sel_we;
        logic [AW-1:0] sel_addr;
        logic [LW-1:0] sel_len;

        // NOTE: every variable gets a default before the case statement so no
        // path leaves a value unassigned, which would infer a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        wr_req_d = wr_req_q;
        rd_req_d = rd_req_q;
        wraddr_d = wraddr_q;
        rdaddr_d = rdaddr_q;
        wrlen_d  = wrlen_q;
        rdlen_d  = rdlen_q;
        done_d   = '0;
        err_d    = '0;
        pick     = 1'b0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_len  = '0;

        case (state_q)
            IDLE: begin
                // A done/err pulse cycle never grants, giving the finished
                // client one cycle to drop its request.
                if (sdram_init_done && (done_q == '0) && (err_q == '0) &&
                    (c0_req || c1_req)) begin
                    pick     = (c0_req && c1_req) ? ~grant_q : c1_req;
                    sel_we   = pick ? c1_we   : c0_we;
                    sel_addr = pick ? c1_addr : c0_addr;
                    sel_len  = pick ? c1_len  : c0_len;
                    grant_d  = pick;
                    we_d     = sel_we;
                    cnt_d    = '0;
                    timer_d  = '0;
                    if (sel_we) begin
                        wraddr_d = sel_addr;
                        wrlen_d  = sel_len;
                    end else begin
                        rdaddr_d = sel_addr;
                        rdlen_d  = sel_len;
                    end
                    if (sel_len == '0) begin
                        done_d[pick] = 1'b1;
                    end else begin
                        state_d  = REQ;
                        wr_req_d = sel_we;
                        rd_req_d = ~sel_we;
                    end
                end
            end
            REQ, BURST: begin
                timer_d = timer_q + TW'(1);
                if (ack_match) begin
                    timer_d  = '0;
                    cnt_d    = cnt_inc;
                    state_d  = BURST;
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    if (cnt_inc == cur_len) begin
                        state_d         = IDLE;
                        done_d[grant_q] = 1'b1;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d        = IDLE;
                    wr_req_d       = 1'b0;
                    rd_req_d       = 1'b0;
                    err_d[grant_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign c0_ack       = ack_match && active && !grant_q;
    assign c1_ack       = ack_match && active &&  grant_q;
    assign c0_rdata     = sys_data_out;
    assign c1_rdata     = sys_data_out;
    assign c0_done      = done_q[0];
    assign c1_done      = done_q[1];
    assign c0_err       = err_q[0];
    assign c1_err       = err_q[1];
    assign sdram_wr_req = wr_req_q;
    assign sdram_rd_req = rd_req_q;
    assign sys_wraddr   = wraddr_q;
    assign sys_rdaddr   = rdaddr_q;
    assign sdwr_byte    = wrlen_q;
    assign sdrd_byte    = rdlen_q;
    assign sys_data_in  = active ? (grant_q ? c1_wdata : c0_wdata) : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Self-checking bench for sdram_arbiter: a table of single-client bursts plus
//   hand-written sequences for init gating, round-robin order, timeout abort,
//   zero-length bursts and reset mid-burst. Each ack the SDRAM model issues
//   pushes the expected client-side word into a scoreboard queue that a
//   negedge monitor pops when the DUT raises cN_ack.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int LW      = 9;
    localparam int TIMEOUT = 1024;

    logic          sys_clk = 1'b0;
    logic          reset_n;
    logic          sdram_init_done;
    logic          c0_req, c0_we, c1_req, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [LW-1:0] c0_len, c1_len;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_ack, c0_done, c0_err, c1_ack, c1_done, c1_err;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
    logic [AW-1:0] sys_wraddr, sys_rdaddr;
    logic [LW-1:0] sdwr_byte, sdrd_byte;
    logic [DW-1:0] sys_data_in, sys_data_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic          client;
        logic          we;
        logic [DW-1:0] word;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        int            client;
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] base;
        bit            noise;
        logic [1:0]    exp_req;   // {sdram_wr_req, sdram_rd_req} while requesting
    } vec_t;

    vec_t vecs[6];

    always #5 sys_clk = ~sys_clk;

    sdram_arbiter #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .sdram_init_done(sdram_init_done),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_len(c0_len),
        .c0_wdata(c0_wdata), .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c0_done(c0_done), .c0_err(c0_err),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_len(c1_len),
        .c1_wdata(c1_wdata), .c1_ack(c1_ack), .c1_rdata(c1_rdata),
        .c1_done(c1_done), .c1_err(c1_err),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sys_wraddr(sys_wraddr), .sys_rdaddr(sys_rdaddr),
        .sdwr_byte(sdwr_byte), .sdrd_byte(sdrd_byte),
        .sys_data_in(sys_data_in), .sys_data_out(sys_data_out)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every client ack must match the oldest expected word.
    always @(negedge sys_clk) begin
        if (c0_ack || c1_ack) begin
            if (c0_ack && c1_ack) check("dual_ack", 64'(1), 64'(0));
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'({c1_ack, c0_ack}), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("ack_client", 64'(c1_ack), 64'(mon_e.client));
                check("ack_data", 64'(mon_e.we ? sys_data_in : (c1_ack ? c1_rdata : c0_rdata)),
                      64'(mon_e.word));
            end
        end
    end

    task automatic set_req(input int n, input logic we, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic [DW-1:0] base);
        if (n == 0) begin
            c0_req = 1'b1; c0_we = we; c0_addr = addr; c0_len = len; c0_wdata = base;
        end else begin
            c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_len = len; c1_wdata = base;
        end
    endtask

    task automatic wait_sdram_req(output bit seen);
        int waited = 0;
        while (!(sdram_wr_req || sdram_rd_req) && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        seen = (sdram_wr_req || sdram_rd_req);
        check("req_seen", 64'(seen), 64'(1));
    endtask

    // Serve one burst already requested by client n: SDRAM model acks one word
    // per cycle, then the client drops its request the cycle after done.
    task automatic serve(input int n, input logic we, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic [DW-1:0] base,
                         input bit noise, input logic [1:0] exp_req);
        bit   seen;
        logic early = 1'b0;
        wait_sdram_req(seen);
        if (!seen) return;
        check("req_type", 64'({sdram_wr_req, sdram_rd_req}), 64'(exp_req));
        check("latched_addr", 64'(we ? sys_wraddr : sys_rdaddr), 64'(addr));
        check("latched_len", 64'(we ? sdwr_byte : sdrd_byte), 64'(len));
        if (noise) begin
            @(posedge sys_clk); #1;
            if (we) sdram_rd_ack = 1'b1; else sdram_wr_ack = 1'b1;
            @(negedge sys_clk);
            check("wrong_ack_ignored", 64'(we ? sdram_wr_req : sdram_rd_req), 64'(1));
        end
        for (int k = 0; k < int'(len); k++) begin
            @(posedge sys_clk); #1;
            sdram_wr_ack = we;
            sdram_rd_ack = !we;
            if (we) begin
                if (n == 0) c0_wdata = DW'(base + k); else c1_wdata = DW'(base + k);
            end else begin
                sys_data_out = DW'(base + k);
            end
            sb.push_back('{client: n[0], we: we, word: DW'(base + k)});
            @(negedge sys_clk);
            early |= (c0_done | c1_done);
            if (k == 0) check("req_until_first_ack", 64'({sdram_wr_req, sdram_rd_req}), 64'(exp_req));
            if (k == 1) check("req_dropped", 64'({sdram_wr_req, sdram_rd_req}), 64'(0));
        end
        @(posedge sys_clk); #1;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        @(negedge sys_clk);
        check("no_early_done", 64'(early), 64'(0));
        check("done_pulse", 64'({c1_done, c0_done}), 64'(n == 0 ? 2'b01 : 2'b10));
        check("no_err", 64'({c1_err, c0_err}), 64'(0));
        check("idle_no_req", 64'({sdram_wr_req, sdram_rd_req}), 64'(0));
        check("sb_drained", 64'(sb.size()), 64'(0));
        @(posedge sys_clk); #1;
        if (n == 0) c0_req = 1'b0; else c1_req = 1'b0;
        @(negedge sys_clk);
        check("done_one_cycle", 64'({c1_done, c0_done}), 64'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_strobes"}, 64'({sdram_wr_req, sdram_rd_req, c0_ack, c1_ack,
                                      c0_done, c1_done, c0_err, c1_err}), 64'(0));
        check({tag, "_addr"}, 64'({sys_wraddr, sys_rdaddr}), 64'(0));
        check({tag, "_len"}, 64'({sdwr_byte, sdrd_byte}), 64'(0));
        check({tag, "_data_in"}, 64'(sys_data_in), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        reset_n = 1'b0;
        #1 check_idle_outputs("reset");
        @(posedge sys_clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int cnt;
        logic acc;

        vecs[0] = '{0, 1'b1, 24'h000000, 9'd8,   16'h0100, 1'b0, 2'b10};
        vecs[1] = '{1, 1'b0, 24'h000100, 9'd4,   16'h5500, 1'b0, 2'b01};
        vecs[2] = '{0, 1'b0, 24'hABCDEF, 9'd1,   16'h7000, 1'b1, 2'b01};
        vecs[3] = '{1, 1'b1, 24'hFFFFFF, 9'd1,   16'h8000, 1'b1, 2'b10};
        vecs[4] = '{1, 1'b1, 24'h123456, 9'd5,   16'h9000, 1'b1, 2'b10};
        vecs[5] = '{0, 1'b0, 24'h000200, 9'd256, 16'hA000, 1'b0, 2'b01};

        reset_n = 1'b0; sdram_init_done = 1'b0;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_len = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_len = '0; c1_wdata = '0;
        sdram_wr_ack = 0; sdram_rd_ack = 0; sys_data_out = '0;
        #1 check_idle_outputs("por");
        repeat (2) @(posedge sys_clk);
        #1 reset_n = 1'b1;

        // No grant while sdram_init_done is low; request reaches sdram 2 cycles after it rises.
        set_req(0, 1'b1, 24'h000010, 9'd2, 16'h1000);
        acc = 1'b0;
        repeat (10) begin
            @(negedge sys_clk);
            acc |= sdram_wr_req | sdram_rd_req;
        end
        check("no_grant_before_init", 64'(acc), 64'(0));
        @(posedge sys_clk); #1;
        sdram_init_done = 1'b1;
        @(negedge sys_clk);
        check("init_lat_cycle1", 64'(sdram_wr_req), 64'(0));
        @(negedge sys_clk);
        check("init_lat_cycle2", 64'(sdram_wr_req), 64'(1));
        serve(0, 1'b1, 24'h000010, 9'd2, 16'h1000, 1'b0, 2'b10);

        // Round robin: after reset last_grant=1 so c0 wins a tie; later a tie
        // after a c0 burst goes to c1.
        do_reset();
        set_req(0, 1'b1, 24'h000020, 9'd3, 16'h2000);
        set_req(1, 1'b0, 24'h000040, 9'd2, 16'h3000);
        serve(0, 1'b1, 24'h000020, 9'd3, 16'h2000, 1'b0, 2'b10);
        serve(1, 1'b0, 24'h000040, 9'd2, 16'h3000, 1'b0, 2'b01);
        @(posedge sys_clk); #1;
        set_req(0, 1'b0, 24'h000060, 9'd2, 16'h3100);
        serve(0, 1'b0, 24'h000060, 9'd2, 16'h3100, 1'b0, 2'b01);
        @(posedge sys_clk); #1;
        set_req(0, 1'b1, 24'h000080, 9'd2, 16'h3200);
        set_req(1, 1'b1, 24'h0000A0, 9'd3, 16'h3300);
        serve(1, 1'b1, 24'h0000A0, 9'd3, 16'h3300, 1'b0, 2'b10);
        serve(0, 1'b1, 24'h000080, 9'd2, 16'h3200, 1'b0, 2'b10);

        // Table of single-client bursts.
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk); #1;
            set_req(vecs[i].client, vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].base);
            serve(vecs[i].client, vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].base,
                  vecs[i].noise, vecs[i].exp_req);
        end

        // Timeout: c0 never acked, c1 waits and is served afterwards.
        @(posedge sys_clk); #1;
        set_req(0, 1'b1, 24'h000055, 9'd4, 16'hB000);
        wait_sdram_req(seen);
        set_req(1, 1'b0, 24'h000077, 9'd2, 16'hC000);
        cnt = 0;
        while (sdram_wr_req && cnt < 2 * TIMEOUT) begin
            cnt++;
            @(negedge sys_clk);
        end
        check("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
        check("timeout_err", 64'({c1_err, c0_err}), 64'(2'b01));
        check("timeout_no_done", 64'({c1_done, c0_done}), 64'(0));
        @(posedge sys_clk); #1;
        c0_req = 1'b0;
        @(negedge sys_clk);
        check("err_one_cycle", 64'({c1_err, c0_err}), 64'(0));
        serve(1, 1'b0, 24'h000077, 9'd2, 16'hC000, 1'b0, 2'b01);

        // Zero-length burst: done next cycle, no SDRAM access.
        @(posedge sys_clk); #1;
        set_req(0, 1'b1, 24'h000099, 9'd0, 16'h0000);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("len0_done", 64'({c1_done, c0_done}), 64'(2'b01));
        check("len0_no_req", 64'({sdram_wr_req, sdram_rd_req}), 64'(0));
        @(posedge sys_clk); #1;
        c0_req = 1'b0;
        acc = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            acc |= sdram_wr_req | sdram_rd_req | c0_done;
        end
        check("len0_quiet_after", 64'(acc), 64'(0));

        // Reset mid-burst: outputs clear immediately, even with an ack present.
        @(posedge sys_clk); #1;
        set_req(1, 1'b0, 24'h000300, 9'd8, 16'hD000);
        wait_sdram_req(seen);
        for (int k = 0; k < 3; k++) begin
            @(posedge sys_clk); #1;
            sdram_rd_ack = 1'b1;
            sys_data_out = DW'(16'hD000 + k);
            sb.push_back('{client: 1'b1, we: 1'b0, word: DW'(16'hD000 + k)});
        end
        @(posedge sys_clk); #1;
        reset_n = 1'b0;
        #1 check_idle_outputs("mid_burst_reset");
        sdram_rd_ack = 1'b0;
        c1_req = 1'b0;
        @(posedge sys_clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("final_sb_empty", 64'(sb.size()), 64'(0));
        check("final_idle", 64'({sdram_wr_req, sdram_rd_req, c0_done, c1_done}), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
